// File: rtl/board_pkg.sv
// Shared definitions for the playfield storage / line-clear engine.
// Holds default geometry, the clear-engine state type and the row type.
package board_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_AW   = 5;

    localparam logic [BOARD_COLS-1:0] FULL_ROW = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } clr_state_t;

    typedef logic [BOARD_COLS-1:0] row_t;

endpackage

// File: rtl/board_matrix.sv
// Playfield register array with OR-merge writes, combinational read port and a
// bottom-up line-clear engine that removes full rows and reports the count.
module board_matrix #(
    parameter int ROWS = board_pkg::BOARD_ROWS,
    parameter int COLS = board_pkg::BOARD_COLS,
    parameter int AW   = board_pkg::BOARD_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [COLS-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [COLS-1:0] rd_data,
    input  logic            clear_start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   lines_cleared,
    output logic [15:0]     score_total,
    output logic            wr_drop
);
    import board_pkg::*;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    logic [COLS-1:0] row_q [ROWS];
    logic [COLS-1:0] row_d [ROWS];
    clr_state_t      state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   lines_q, lines_d;
    logic [15:0]     score_q, score_d;
    logic            wr_drop_q, wr_drop_d;
    logic            wr_ok;
    logic            row_full;
    logic [16:0]     score_sum;

    assign wr_ok     = (state_q == IDLE) && (wr_addr <= LAST_ROW);
    assign row_full  = &row_q[ptr_q];
    assign score_sum = {1'b0, score_q} + 17'(cnt_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lines_d   = lines_q;
        score_d   = score_q;
        wr_drop_d = wr_en && !wr_ok;
        row_d     = row_q;

        case (state_q)
            IDLE: begin
                if (wr_en && wr_ok) begin
                    row_d[wr_addr] = row_q[wr_addr] | wr_data;
                end
                if (clear_start) begin
                    state_d = SCAN;
                    ptr_d   = LAST_ROW;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (ptr_q == '0) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q - AW'(1);
                end
            end
            SHIFT: begin
                // Everything at or above ptr drops one row; ptr is rescanned next.
                row_d[0] = '0;
                for (int i = 1; i < ROWS; i++) begin
                    if (i <= int'(ptr_q)) begin
                        row_d[i] = row_q[i-1];
                    end
                end
                cnt_d   = cnt_q + AW'(1);
                state_d = SCAN;
            end
            DONE: begin
                lines_d = cnt_q;
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            lines_q   <= '0;
            score_q   <= '0;
            wr_drop_q <= 1'b0;
            // NOTE: the board is a flop array, so it can and must be cleared by reset.
            row_q     <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lines_q   <= lines_d;
            score_q   <= score_d;
            wr_drop_q <= wr_drop_d;
            row_q     <= row_d;
        end
    end

    assign rd_data       = (rd_addr <= LAST_ROW) ? row_q[rd_addr] : '0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_q;
    assign score_total   = score_q;
    assign wr_drop       = wr_drop_q;

endmodule
